qar_can_rx_fifo: RTL

QAR_CAN_RX_FIFO -- requirements
Module: qar_can_rx_fifo

---
 rtl/qar_can_rx_fifo.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/qar_can_rx_fifo.sv
// CAN receive FIFO: acceptance filtering, DLC clamp with payload zeroing, frame FIFO
// with sticky overflow, saturating drop counter and a level/overflow interrupt.
module qar_can_rx_fifo #(
    parameter  int unsigned DEPTH       = 4,
    parameter  int unsigned NUM_FILTERS = 2,
    parameter  int unsigned IRQ_LEVEL   = 1,
    localparam int unsigned LW          = $clog2(DEPTH) + 1,
    localparam int unsigned FW          = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      rx_valid_i,
    input  logic [10:0]               rx_id_i,
    input  logic [3:0]                rx_dlc_i,
    input  logic [63:0]               rx_data_i,
    input  logic [11*NUM_FILTERS-1:0] filt_id_i,
    input  logic [11*NUM_FILTERS-1:0] filt_mask_i,
    input  logic [NUM_FILTERS-1:0]    filt_en_i,
    input  logic                      pop_i,
    input  logic                      ovf_clr_i,
    output logic                      head_valid_o,
    output logic [10:0]               head_id_o,
    output logic [3:0]                head_dlc_o,
    output logic [63:0]               head_data_o,
    output logic [FW-1:0]             head_hit_o,
    output logic [LW-1:0]             level_o,
    output logic                      ovf_o,
    output logic [7:0]                drop_cnt_o,
    output logic                      irq_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [10:0]   slot_id_q   [DEPTH];
    logic [3:0]    slot_dlc_q  [DEPTH];
    logic [63:0]   slot_data_q [DEPTH];
    logic [FW-1:0] slot_hit_q  [DEPTH];

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;

    logic [NUM_FILTERS-1:0] match;
    logic                   any_match;
    logic [FW-1:0]          hit_idx;
    logic                   accept;
    logic [3:0]             dlc_eff;
    logic [63:0]            data_eff;
    logic                   full, not_empty;
    logic                   do_push, do_pop, do_drop;

    // Filter match; scanning from the top down leaves the lowest matching index in hit_idx.
    always_comb begin
        match     = '0;
        any_match = 1'b0;
        hit_idx   = '0;
        for (int unsigned i = 0; i < NUM_FILTERS; i++) begin
            match[i] = filt_en_i[i] &&
                       (((rx_id_i ^ filt_id_i[11*i +: 11]) & filt_mask_i[11*i +: 11]) == 11'd0);
        end
        for (int unsigned i = 0; i < NUM_FILTERS; i++) begin
            if (match[NUM_FILTERS-1-i]) begin
                hit_idx   = FW'(NUM_FILTERS-1-i);
                any_match = 1'b1;
            end
        end
        if (filt_en_i == '0) begin
            hit_idx   = '0;
            any_match = 1'b1;
        end
        accept = rx_valid_i & any_match;
    end

    always_comb begin
        dlc_eff  = (rx_dlc_i > 4'd8) ? 4'd8 : rx_dlc_i;
        data_eff = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (k < 32'(dlc_eff)) begin
                data_eff[63-8*k -: 8] = rx_data_i[63-8*k -: 8];
            end
        end
    end

    always_comb begin
        not_empty = (level_q != '0);
        full      = (level_q == LW'(DEPTH));
        do_pop    = pop_i & not_empty;
        do_push   = accept & (~full | do_pop);
        do_drop   = accept & full & ~do_pop;

        wptr_d  = do_push ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = do_pop  ? rptr_q + AW'(1) : rptr_q;
        level_d = level_q + LW'(do_push) - LW'(do_pop);

        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;
        if (ovf_clr_i) begin
            ovf_d      = 1'b0;
            drop_cnt_d = '0;
        end
        // A drop in the clearing cycle restarts the count at one rather than being lost.
        if (do_drop) begin
            ovf_d = 1'b1;
            if (drop_cnt_d != 8'hFF) begin
                drop_cnt_d = drop_cnt_d + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            slot_id_q[wptr_q]   <= rx_id_i;
            slot_dlc_q[wptr_q]  <= dlc_eff;
            slot_data_q[wptr_q] <= data_eff;
            slot_hit_q[wptr_q]  <= hit_idx;
        end
    end

    always_comb begin
        head_valid_o = not_empty;
        head_id_o    = not_empty ? slot_id_q[rptr_q]   : '0;
        head_dlc_o   = not_empty ? slot_dlc_q[rptr_q]  : '0;
        head_data_o  = not_empty ? slot_data_q[rptr_q] : '0;
        head_hit_o   = not_empty ? slot_hit_q[rptr_q]  : '0;
        level_o      = level_q;
        ovf_o        = ovf_q;
        drop_cnt_o   = drop_cnt_q;
        irq_o        = (level_q >= LW'(IRQ_LEVEL)) | ovf_q;
    end

endmodule
